// File: rtl/jam_pkg.sv
// jam_pkg: shared sizes and server state encoding for the job-assignment cost server.
package jam_pkg;
  localparam int N      = 8;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = $clog2(N);
  localparam int TBL_W  = $clog2(N * N);
  typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DONE} srv_state_e;
endpackage

// File: rtl/jam_cost_mem.sv
// jam_cost_mem: N*N cost register file, one write port and one registered read port.
module jam_cost_mem
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              we_i,
  input  logic [TBL_W-1:0]  waddr_i,
  input  logic [COST_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [TBL_W-1:0]  raddr_i,
  output logic [COST_W-1:0] rdata_o
);
  logic [COST_W-1:0] mem_q [N*N];
  logic [COST_W-1:0] rdata_q;
  // Contents are deliberately not reset; only the read register is.
  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rdata_q <= '0;
    else     rdata_q <= re_i ? mem_q[raddr_i] : '0;
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/jam_cost_server.sv
// jam_cost_server: serial cost-table loader, 1-cycle Cost[W][J] lookup and solver result capture.
// Optional JAM_LOOKUP_CNT_EN adds a saturating count of serving cycles on lookup_count.
module jam_cost_server
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  input  logic              reload,
  output logic              table_ready,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [CNT_W-1:0]  MatchCount,
  input  logic [SUM_W-1:0]  MinCost,
  output logic              result_valid,
  output logic [CNT_W-1:0]  result_match,
  output logic [SUM_W-1:0]  result_min
`ifdef JAM_LOOKUP_CNT_EN
  ,
  output logic [19:0]       lookup_count
`endif
);
  localparam logic [IDX_W:0]   N_EXT = (IDX_W + 1)'(N);
  localparam logic [TBL_W-1:0] LAST  = TBL_W'(N * N - 1);
  srv_state_e        state_q, state_d;
  logic [TBL_W-1:0]  idx_q, idx_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  res_match_q, res_match_d;
  logic [SUM_W-1:0]  res_min_q, res_min_d;
  logic              loading, last_beat, in_range;
  logic [TBL_W-1:0]  raddr;
  assign loading   = state_q == S_LOAD;
  assign last_beat = idx_q == LAST;
  // Guards non-power-of-2 N; always true at N=8.
  assign in_range  = ({1'b0, W} < N_EXT) && ({1'b0, J} < N_EXT);
  assign raddr     = TBL_W'(W * N + J);
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    res_valid_d = res_valid_q;
    res_match_d = res_match_q;
    res_min_d   = res_min_q;
    if (reload) begin
      state_d     = S_LOAD;
      idx_d       = '0;
      res_valid_d = 1'b0;
    end else if (loading && load_valid) begin
      idx_d   = last_beat ? '0 : idx_q + TBL_W'(1);
      state_d = last_beat ? S_SERVE : S_LOAD;
    end else if (!loading && Valid) begin
      state_d     = S_DONE;
      res_valid_d = 1'b1;
      res_match_d = MatchCount;
      res_min_d   = MinCost;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      res_match_q <= '0;
      res_min_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_min_q   <= res_min_d;
    end
  end
  jam_cost_mem u_mem (
    .CLK     (CLK),
    .RST     (RST),
    .we_i    (loading && load_valid && !reload),
    .waddr_i (idx_q),
    .wdata_i (load_data),
    .re_i    (!loading && in_range),
    .raddr_i (raddr),
    .rdata_o (Cost)
  );
  assign load_ready   = loading;
  assign table_ready  = !loading;
  assign result_valid = res_valid_q;
  assign result_match = res_match_q;
  assign result_min   = res_min_q;
`ifdef JAM_LOOKUP_CNT_EN
  logic [19:0] lcnt_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                           lcnt_q <= '0;
    else if (reload)                                   lcnt_q <= '0;
    else if (state_q == S_SERVE && lcnt_q != 20'hFFFFF) lcnt_q <= lcnt_q + 20'd1;
  end
  assign lookup_count = lcnt_q;
`endif
endmodule
